// File: rtl/round_ctrl_if.sv
// Player/host bundle for the card-round controller; master = players and host, slave = controller.
interface round_ctrl_if;
  logic       start;
  logic [8:0] p1_sel;
  logic [8:0] p2_sel;
  logic       p1_go;
  logic       p2_go;
  logic [8:0] p1_used;
  logic [8:0] p2_used;
  logic [3:0] p1_handcard;
  logic [3:0] p2_handcard;
  logic [8:0] p1_cardselect;
  logic [8:0] p2_cardselect;
  logic       p1_handout_pulse;
  logic       p2_handout_pulse;
  logic [1:0] turn;
  logic [3:0] round;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       err;
  logic       done;
  logic [1:0] winner;

  modport master (
    output start, p1_sel, p2_sel, p1_go, p2_go,
           p1_used, p2_used, p1_handcard, p2_handcard,
    input  p1_cardselect, p2_cardselect, p1_handout_pulse, p2_handout_pulse,
           turn, round, p1_score, p2_score, err, done, winner
  );

  modport slave (
    input  start, p1_sel, p2_sel, p1_go, p2_go,
           p1_used, p2_used, p1_handcard, p2_handcard,
    output p1_cardselect, p2_cardselect, p1_handout_pulse, p2_handout_pulse,
           turn, round, p1_score, p2_score, err, done, winner
  );
endinterface

// File: rtl/round_ctrl.sv
// Two-player card game round controller (optional auto-play via ROUND_TIMEOUT_EN).
// Latency: accepted go -> cardselect next cycle, handout pulse the cycle after.
// Backpressure: none; only the player in turn is observed, bad go flags err.
module round_ctrl #(
  parameter int NROUNDS        = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOAD,
    S_PULSE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [1:0] TURN_NONE  = 2'b00;
  localparam logic [1:0] TURN_P1    = 2'b01;
  localparam logic [1:0] TURN_P2    = 2'b10;
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  state_t     state;
  logic [3:0] round_q;
  logic [3:0] p1_score_q;
  logic [3:0] p2_score_q;
  logic [1:0] turn_q;
  logic [1:0] winner_q;
  logic [8:0] p1_cs_q;
  logic [8:0] p2_cs_q;
  logic       p1_pulse_q;
  logic       p2_pulse_q;
  logic       err_q;
  logic       done_q;
  logic       served_q;

  logic       p1_act;
  logic       act_go;
  logic [8:0] act_sel;
  logic [8:0] act_used;
  logic       sel_onehot;
  logic       go_ok;
  logic       p1_wins;
  logic       p2_wins;
  logic [3:0] p1_score_nxt;
  logic [3:0] p2_score_nxt;
  logic [1:0] winner_nxt;
  logic [1:0] lead_nxt;
  logic       tmo_fire;
  logic [8:0] auto_sel;
  logic [8:0] pick_sel;

  assign p1_act     = (turn_q == TURN_P1);
  assign act_go     = p1_act ? bus.p1_go   : bus.p2_go;
  assign act_sel    = p1_act ? bus.p1_sel  : bus.p2_sel;
  assign act_used   = p1_act ? bus.p1_used : bus.p2_used;
  assign sel_onehot = (act_sel != 9'd0) && ((act_sel & (act_sel - 9'd1)) == 9'd0);
  assign go_ok      = act_go && sel_onehot && ((act_sel & act_used) == 9'd0);
  assign pick_sel   = go_ok ? act_sel : auto_sel;

  assign p1_wins      = (bus.p1_handcard > bus.p2_handcard);
  assign p2_wins      = (bus.p2_handcard > bus.p1_handcard);
  assign p1_score_nxt = p1_score_q + {3'b000, p1_wins};
  assign p2_score_nxt = p2_score_q + {3'b000, p2_wins};
  assign winner_nxt   = (p1_score_nxt > p2_score_nxt) ? TURN_P1 :
                        (p2_score_nxt > p1_score_nxt) ? TURN_P2 : 2'b11;
  // Odd rounds are led by P1, so the round after an odd one is led by P2.
  assign lead_nxt     = round_q[0] ? TURN_P2 : TURN_P1;

`ifdef ROUND_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic [8:0]    free_mask;

  assign free_mask = ~act_used;
  assign auto_sel  = free_mask & (~free_mask + 9'd1);
  assign tmo_fire  = (state == S_WAIT) && (tmo_cnt == TMO_LAST) && (auto_sel != 9'd0);

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign auto_sel = 9'd0;
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      round_q    <= 4'd0;
      p1_score_q <= 4'd0;
      p2_score_q <= 4'd0;
      turn_q     <= TURN_NONE;
      winner_q   <= 2'b00;
      p1_cs_q    <= 9'd0;
      p2_cs_q    <= 9'd0;
      p1_pulse_q <= 1'b0;
      p2_pulse_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      served_q   <= 1'b0;
    end else begin
      err_q      <= 1'b0;
      p1_pulse_q <= 1'b0;
      p2_pulse_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_WAIT;
            round_q    <= 4'd1;
            p1_score_q <= 4'd0;
            p2_score_q <= 4'd0;
            turn_q     <= TURN_P1;
            winner_q   <= 2'b00;
            done_q     <= 1'b0;
            served_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          err_q <= act_go && !go_ok;
          if (go_ok || tmo_fire) begin
            state <= S_LOAD;
            if (p1_act) p1_cs_q <= pick_sel;
            else        p2_cs_q <= pick_sel;
          end
        end
        S_LOAD: begin
          state <= S_PULSE;
          if (p1_act) p1_pulse_q <= 1'b1;
          else        p2_pulse_q <= 1'b1;
        end
        S_PULSE: begin
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          p1_cs_q <= 9'd0;
          p2_cs_q <= 9'd0;
          if (!served_q) begin
            served_q <= 1'b1;
            turn_q   <= p1_act ? TURN_P2 : TURN_P1;
            state    <= S_WAIT;
          end else begin
            turn_q   <= TURN_NONE;
            state    <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          p1_score_q <= p1_score_nxt;
          p2_score_q <= p2_score_nxt;
          served_q   <= 1'b0;
          if (round_q < LAST_ROUND) begin
            round_q <= round_q + 4'd1;
            turn_q  <= lead_nxt;
            state   <= S_WAIT;
          end else begin
            done_q   <= 1'b1;
            winner_q <= winner_nxt;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.p1_cardselect    = p1_cs_q;
  assign bus.p2_cardselect    = p2_cs_q;
  assign bus.p1_handout_pulse = p1_pulse_q;
  assign bus.p2_handout_pulse = p2_pulse_q;
  assign bus.turn             = turn_q;
  assign bus.round            = round_q;
  assign bus.p1_score         = p1_score_q;
  assign bus.p2_score         = p2_score_q;
  assign bus.err              = err_q;
  assign bus.done             = done_q;
  assign bus.winner           = winner_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a stub handout datapath per player.
module tb_round_ctrl;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  round_ctrl_if bus();

  round_ctrl #(.NROUNDS(9), .TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] m1_used, m2_used, x1_used, x2_used;
  logic [3:0] m1_card, m2_card;

  int c1_tab [9] = '{7, 1, 5, 2, 4, 6, 3, 8, 9};
  int c2_tab [9] = '{3, 9, 1, 8, 4, 2, 7, 5, 6};
  int s1_tab [9] = '{1, 1, 2, 2, 2, 3, 3, 4, 5};
  int s2_tab [9] = '{0, 1, 1, 2, 2, 2, 3, 3, 3};

  function automatic logic [3:0] enc(input logic [8:0] s);
    logic [3:0] v;
    v = 4'd0;
    for (int k = 0; k < 9; k++) if (s[k]) v = 4'(k + 1);
    return v;
  endfunction

  function automatic logic [8:0] onehot(input int c);
    logic [8:0] one;
    one = 9'd1;
    return one << (c - 1);
  endfunction

  // Handout datapath stub: latches the card on its strobe, cleared by the shared reset.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m1_used <= 9'd0;
      m2_used <= 9'd0;
      m1_card <= 4'd0;
      m2_card <= 4'd0;
    end else begin
      if (bus.p1_handout_pulse) begin
        m1_used <= m1_used | bus.p1_cardselect;
        m1_card <= enc(bus.p1_cardselect);
      end
      if (bus.p2_handout_pulse) begin
        m2_used <= m2_used | bus.p2_cardselect;
        m2_card <= enc(bus.p2_cardselect);
      end
    end
  end

  assign bus.p1_used     = m1_used | x1_used;
  assign bus.p2_used     = m2_used | x2_used;
  assign bus.p1_handcard = m1_card;
  assign bus.p2_handcard = m2_card;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_turn(input logic [1:0] t);
    for (int i = 0; i < 20 && bus.turn != t; i++) tick();
    check("turn_ready", 32'(bus.turn), 32'(t));
  endtask

  task automatic play(input int p, input int c, input logic with_start);
    wait_turn(p == 1 ? 2'b01 : 2'b10);
    if (p == 1) begin
      bus.p1_sel = onehot(c);
      bus.p1_go  = 1'b1;
    end else begin
      bus.p2_sel = onehot(c);
      bus.p2_go  = 1'b1;
    end
    bus.start = with_start;
    tick();
    bus.p1_go = 1'b0;
    bus.p2_go = 1'b0;
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    if (bus.turn == 2'b00) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.start  = 1'b0;
    bus.p1_go  = 1'b0;
    bus.p2_go  = 1'b0;
    bus.p1_sel = 9'd0;
    bus.p2_sel = 9'd0;
    x1_used    = 9'd0;
    x2_used    = 9'd0;
    resetn     = 1'b0;
    #12;
    check("rst_turn",   32'(bus.turn), 0);
    check("rst_round",  32'(bus.round), 0);
    check("rst_p1s",    32'(bus.p1_score), 0);
    check("rst_p2s",    32'(bus.p2_score), 0);
    check("rst_err",    32'(bus.err), 0);
    check("rst_done",   32'(bus.done), 0);
    check("rst_winner", 32'(bus.winner), 0);
    check("rst_p1cs",   32'(bus.p1_cardselect), 0);
    check("rst_p1pul",  32'(bus.p1_handout_pulse), 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("idle_turn", 32'(bus.turn), 0);

    // Game A: first play timing, then reset in the middle of P2's pulse.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_turn",  32'(bus.turn), 1);
    check("start_round", 32'(bus.round), 1);
    bus.p1_sel = 9'h004;
    bus.p1_go  = 1'b1;
    tick();
    bus.p1_go = 1'b0;
    check("load_cs",    32'(bus.p1_cardselect), 32'h004);
    check("load_pulse", 32'(bus.p1_handout_pulse), 0);
    tick();
    check("pulse_hi",    32'(bus.p1_handout_pulse), 1);
    check("pulse_p2_lo", 32'(bus.p2_handout_pulse), 0);
    tick();
    check("pulse_lo",  32'(bus.p1_handout_pulse), 0);
    check("settle_cs", 32'(bus.p1_cardselect), 32'h004);
    tick();
    check("turn_p2", 32'(bus.turn), 2);
    bus.p2_sel = 9'h002;
    bus.p2_go  = 1'b1;
    tick();
    bus.p2_go = 1'b0;
    tick();
    check("p2_pulse_hi", 32'(bus.p2_handout_pulse), 1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_pulse", 32'(bus.p2_handout_pulse), 0);
    check("mid_rst_cs",    32'(bus.p2_cardselect), 0);
    check("mid_rst_turn",  32'(bus.turn), 0);
    check("mid_rst_round", 32'(bus.round), 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("rel_idle", 32'(bus.turn), 0);

    // Game B: full nine rounds.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b_round", 32'(bus.round), 1);
    check("b_turn",  32'(bus.turn), 1);
    check("b_p1s",   32'(bus.p1_score), 0);

    x1_used    = 9'h001;
    bus.p1_sel = 9'h006;
    bus.p1_go  = 1'b1;
    tick();
    bus.p1_go = 1'b0;
    check("err_multi",    32'(bus.err), 1);
    check("err_multi_cs", 32'(bus.p1_cardselect), 0);
    tick();
    check("err_clear",       32'(bus.err), 0);
    check("err_multi_pulse", 32'(bus.p1_handout_pulse), 0);
    bus.p1_sel = 9'h001;
    bus.p1_go  = 1'b1;
    tick();
    bus.p1_go = 1'b0;
    check("err_used",    32'(bus.err), 1);
    check("err_used_cs", 32'(bus.p1_cardselect), 0);
    tick();
    check("err_used_pulse", 32'(bus.p1_handout_pulse), 0);
    check("err_turn",       32'(bus.turn), 1);
    x1_used = 9'd0;

    play(1, c1_tab[0], 1'b0);
    bus.p1_sel = 9'h100;
    bus.p1_go  = 1'b1;
    tick();
    bus.p1_go = 1'b0;
    check("offturn_err",  32'(bus.err), 0);
    check("offturn_cs",   32'(bus.p1_cardselect), 0);
    check("offturn_turn", 32'(bus.turn), 2);
    play(2, c2_tab[0], 1'b0);
    check("r1_p1s",   32'(bus.p1_score), 1);
    check("r1_p2s",   32'(bus.p2_score), 0);
    check("r1_round", 32'(bus.round), 2);
    check("r1_turn",  32'(bus.turn), 2);

    for (int r = 2; r <= 9; r++) begin
      if (r % 2 == 1) begin
        play(1, c1_tab[r-1], 1'b0);
        play(2, c2_tab[r-1], 1'b0);
      end else begin
        play(2, c2_tab[r-1], r == 2);
        play(1, c1_tab[r-1], 1'b0);
      end
      check($sformatf("r%0d_p1s", r), 32'(bus.p1_score), 32'(s1_tab[r-1]));
      check($sformatf("r%0d_p2s", r), 32'(bus.p2_score), 32'(s2_tab[r-1]));
      check($sformatf("r%0d_round", r), 32'(bus.round), (r < 9) ? 32'(r + 1) : 32'd9);
      check($sformatf("r%0d_turn", r), 32'(bus.turn),
            (r < 9) ? (((r + 1) % 2 == 1) ? 32'd1 : 32'd2) : 32'd0);
    end
    check("done_flag",   32'(bus.done), 1);
    check("done_winner", 32'(bus.winner), 1);

    bus.p1_sel = 9'h001;
    bus.p2_sel = 9'h001;
    bus.p1_go  = 1'b1;
    bus.p2_go  = 1'b1;
    tick();
    bus.p1_go = 1'b0;
    bus.p2_go = 1'b0;
    check("done_go_err", 32'(bus.err), 0);
    check("done_go_cs",  32'(bus.p1_cardselect), 0);
    tick();
    check("done_go_pulse", 32'(bus.p1_handout_pulse), 0);
    check("done_frozen",   32'(bus.p1_score), 5);
    check("done_hold",     32'(bus.done), 1);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_done",   32'(bus.done), 0);
    check("restart_round",  32'(bus.round), 1);
    check("restart_p1s",    32'(bus.p1_score), 0);
    check("restart_winner", 32'(bus.winner), 0);

    // Idle P1 with cards 1 and 2 already gone.
    resetn = 1'b0;
    @(negedge clk);
    resetn  = 1'b1;
    x1_used = 9'h003;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
`ifdef ROUND_TIMEOUT_EN
    repeat (15) tick();
    check("tmo_early_cs", 32'(bus.p1_cardselect), 0);
    tick();
    check("tmo_cs", 32'(bus.p1_cardselect), 32'h004);
    tick();
    check("tmo_pulse", 32'(bus.p1_handout_pulse), 1);
`else
    repeat (40) tick();
    check("hold_cs",    32'(bus.p1_cardselect), 0);
    check("hold_pulse", 32'(bus.p1_handout_pulse), 0);
    check("hold_turn",  32'(bus.turn), 1);
`endif
    x1_used = 9'd0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter NROUNDS, default 9, number of rounds per game (1..9).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, idle cycles before auto-play (used only with ROUND_TIMEOUT_EN).
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a game; honoured only in IDLE or DONE.
REQ-006 p1_sel / p2_sel  in  9  player card choice, intended one-hot, bit k = card k+1.
REQ-007 p1_go / p2_go  in  1  player commits pN_sel this cycle.
REQ-008 p1_used / p2_used  in  9  played-card mask returned by each player's handout datapath, 1 = already played.
REQ-009 p1_handcard / p2_handcard  in  4  encoded last played card value (1..9) from handout datapath.
REQ-010 p1_cardselect / p2_cardselect  out  9  registered one-hot selection driven to handout datapath.
REQ-011 p1_handout_pulse / p2_handout_pulse  out  1  registered one-cycle strobe to handout datapath.
REQ-012 turn  out  2  01 = P1 to play, 10 = P2 to play, 00 = none.
REQ-013 round  out  4  current round number, 1..NROUNDS, 0 when idle.
REQ-014 p1_score / p2_score  out  4  rounds won.
REQ-015 err  out  1  one-cycle flag: go from active player rejected.
REQ-016 done  out  1  high in DONE; winner  out  2  01 P1, 10 P2, 11 tie, 00 not done.

Function
REQ-017 FSM states IDLE, WAIT, LOAD, PULSE, SETTLE, COMPARE, DONE; exactly one state active.
REQ-018 IDLE --start--> WAIT with round=1, scores=0, leader=P1.
REQ-019 In WAIT only the player in turn is observed; go from the other player is ignored without err.
REQ-020 go accepted iff sel has exactly one bit set, sel has no bit outside [8:0] set, and (sel & pN_used)==0; otherwise err pulses next cycle and FSM stays in WAIT.
REQ-021 Accepted go in cycle N: pN_cardselect = sel from N+1 (LOAD), pN_handout_pulse high in N+2 only (PULSE), cardselect held unchanged through N+3 (SETTLE).
REQ-022 After SETTLE: if second player of round not yet served, turn switches and FSM returns to WAIT; else COMPARE.
REQ-023 COMPARE (one cycle): unsigned compare of p1_handcard vs p2_handcard; higher increments its score by 1; equal changes neither.
REQ-024 Leader alternates: odd rounds P1 first, even rounds P2 first.
REQ-025 After COMPARE: round < NROUNDS -> round+1, WAIT; round == NROUNDS -> DONE.
REQ-026 DONE: done=1, turn=00, winner from score compare, scores frozen; start restarts per REQ-018 and clears done.
REQ-027 Handout pulses never overlap; at most one pulse per player per round.
REQ-028 start outside IDLE/DONE ignored; simultaneous go and start in WAIT: go processed, start ignored.

Reset
REQ-029 resetn low asynchronously forces IDLE, all outputs 0 (cardselect 0, pulses 0, turn 00, round 0, scores 0, err 0, done 0, winner 00), including mid-pulse.
REQ-030 Reset release takes effect on first clk edge with resetn high; handout datapath shares resetn and is cleared simultaneously.

Configuration
REQ-031 Macro ROUND_TIMEOUT_EN defined: counter clears on WAIT entry; after TIMEOUT_CYCLES cycles in WAIT without accepted go, controller selects lowest unused card of the active player and proceeds as REQ-021.
REQ-032 ROUND_TIMEOUT_EN undefined: no counter, WAIT held indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-033 Reset, start, P1 go sel=0x004 -> cardselect 0x004 next cycle, p1_handout_pulse one cycle later, turn=10.
REQ-034 Round 1 P1 card 7, P2 card 3 -> p1_score=1, round=2, turn=10 (P2 leads).
REQ-035 Active go sel=0x006, then sel=0x001 with p1_used=0x001 -> err pulses both times, no pulse, stays WAIT.
REQ-036 Nine rounds, P1 wins 5, P2 wins 3, one tie -> done=1, winner=01, further go ignored.
REQ-037 resetn low during PULSE -> pulse drops immediately, all outputs 0, next start begins round 1.
REQ-038 With ROUND_TIMEOUT_EN, TIMEOUT_CYCLES=16, P1 idle, p1_used=0x003 -> after 16 WAIT cycles cardselect=0x004 and pulse issued.
